// File: rtl/pool_pkg.sv
// pool_pkg -- shared types and helpers for the streaming 2x2 pooling layer.
//
// Contents:
//   pool_mode_e   pooling operator, latched per frame on start
//   pool_state_e  frame control states of pool2d_stream
//   SMAX_W        working width of smax; lane widths up to SMAX_W-2 are supported
//   smax()        signed maximum of two values on the SMAX_W working width.
//                 Callers sign-extend into it and keep the low bits they need.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pool_state_e;

  localparam int SMAX_W = 128;

  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// pool_lane -- combinational datapath for one channel lane of pool2d_stream.
//
// Ports:
//   max_mode  in   1         1 = max pooling, 0 = average pooling
//   h         in   DATA_W    held pixel from the even column of the pair
//   x         in   DATA_W    incoming pixel from the odd column of the pair
//   l         in   DATA_W+1  horizontal pair result of the row above (line buffer)
//   p         out  DATA_W+1  horizontal pair result (sum or max, sign-extended)
//   q         out  DATA_W    2x2 result: floor(sum/4) or max, truncated to DATA_W
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     max_mode,
  input  logic signed [DATA_W-1:0] h,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W:0]   l,
  output logic signed [DATA_W:0]   p,
  output logic signed [DATA_W-1:0] q
);

  logic signed [DATA_W:0]   pair_sum;
  logic signed [DATA_W:0]   pair_max;
  logic signed [DATA_W+1:0] quad_sum;
  logic signed [DATA_W-1:0] quad_avg;
  logic signed [DATA_W-1:0] quad_max;

  // High bits of the wide max results and the two fraction bits of the
  // quad sum are intentionally discarded.
  logic [SMAX_W-DATA_W-2:0] pair_max_unused_hi;
  logic [SMAX_W-DATA_W-1:0] quad_max_unused_hi;
  logic [1:0]               quad_sum_unused_frac;

  // One guard bit keeps the pair sum exact.
  assign pair_sum = $signed({h[DATA_W-1], h}) + $signed({x[DATA_W-1], x});
  assign {pair_max_unused_hi, pair_max} = smax(SMAX_W'(h), SMAX_W'(x));

  // Second guard bit keeps the four-pixel sum exact; dropping the two LSBs
  // of a two's-complement value is an arithmetic shift, i.e. floor(sum/4),
  // and the mean of four DATA_W values always fits back in DATA_W.
  assign quad_sum = $signed({l[DATA_W], l}) + $signed({p[DATA_W], p});
  assign {quad_avg, quad_sum_unused_frac} = quad_sum;
  assign {quad_max_unused_hi, quad_max} = smax(SMAX_W'(l), SMAX_W'(p));

  assign p = max_mode ? pair_max : pair_sum;
  assign q = max_mode ? quad_max : quad_avg;

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream -- streaming 2x2 / stride-2 pooling (average or max) over a
// raster-order pixel stream carrying CH independent lanes per beat.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       one-cycle pulse in IDLE: begins a frame, latches mode
//   mode        0 = average, 1 = max (sampled only on accepted start)
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid && in_ready
//   in_data     CH lanes, lane k = bits [k*DATA_W +: DATA_W]
//   out_valid   pooled beat valid (held until out_ready)
//   out_ready   downstream accept
//   out_data    pooled result, same lane packing as in_data
//   busy        high while a frame is in progress (RUN / FLUSH)
//   done        one-cycle pulse after the last output is accepted
//
// Even rows only fill a half-row line buffer with horizontal pair results;
// odd rows combine the stored pair with the current pair and produce one
// output per odd column, registered for a single cycle of latency.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CH     = 1,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int LW       = CH * (DATA_W + 1);

  pool_state_e state_reg, state_next;
  pool_mode_e  mode_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  logic [CH*DATA_W-1:0] h_reg;
  logic [LW-1:0]        lbuf [LB_DEPTH];
  logic [LW-1:0]        lbuf_rd_reg;

  logic                 out_valid_reg;
  logic [CH*DATA_W-1:0] out_data_reg;

  logic [LW-1:0]        pair_all;
  logic [CH*DATA_W-1:0] quad_all;

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          load;
  logic [AW-1:0] lbuf_addr;

  // Accept a beat only when the output register is free or draining this
  // cycle, so a result is never overwritten while stalled.
  assign in_ready  = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign col_last  = (col_reg == CW'(IMG_W - 1));
  assign row_last  = (row_reg == RW'(IMG_H - 1));
  assign load      = accept && row_reg[0] && col_reg[0];
  assign lbuf_addr = AW'(col_reg >> 1);

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Frame control: state register, mode latch and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= POOL_AVG;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        mode_reg <= pool_mode_e'(mode);
        col_reg  <= '0;
        row_reg  <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (accept && row_last && col_last) state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (out_valid_reg && out_ready) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel hold and line buffer. Both columns of a pair share one buffer
  // address, so odd rows read the stored pair on the even-column beat and the
  // registered read is ready when the odd-column beat arrives.
  always_ff @(posedge clk) begin
    if (accept && !col_reg[0]) h_reg <= in_data;
    if (accept && !row_reg[0] && col_reg[0]) lbuf[lbuf_addr] <= pair_all;
    if (accept && row_reg[0] && !col_reg[0]) lbuf_rd_reg <= lbuf[lbuf_addr];
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      pool_lane #(
        .DATA_W(DATA_W)
      ) u_lane (
        .max_mode(mode_reg == POOL_MAX),
        .h       (h_reg[gi*DATA_W +: DATA_W]),
        .x       (in_data[gi*DATA_W +: DATA_W]),
        .l       (lbuf_rd_reg[gi*(DATA_W+1) +: DATA_W+1]),
        .p       (pair_all[gi*(DATA_W+1) +: DATA_W+1]),
        .q       (quad_all[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Output register: loading a new result takes priority over draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= quad_all;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: a 4x4 single-lane instance and a 10x10 two-lane
// instance share stimulus; sel picks which one is being exercised.
module tb_pool2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, mode, in_valid, out_ready, sel;
  logic [63:0] din;

  logic        ir_a, ov_a, busy_a, done_a;
  logic [31:0] od_a;
  logic        ir_b, ov_b, busy_b, done_b;
  logic [63:0] od_b;

  logic        ir, ov, bsy, dn;
  logic [63:0] od;

  assign ir  = sel ? ir_b   : ir_a;
  assign ov  = sel ? ov_b   : ov_a;
  assign bsy = sel ? busy_b : busy_a;
  assign dn  = sel ? done_b : done_a;
  assign od  = sel ? od_b   : {32'h0, od_a};

  pool2d_stream #(.DATA_W(32), .CH(1), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_a), .in_data(din[31:0]),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .busy(busy_a), .done(done_a)
  );

  pool2d_stream #(.DATA_W(32), .CH(2), .IMG_W(10), .IMG_H(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_b), .in_data(din),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .busy(busy_b), .done(done_b)
  );

  int passes = 0;
  int total  = 0;
  logic [63:0] img [100];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [63:0] l0(input int v);
    return {32'h0, 32'(v)};
  endfunction

  task automatic fill_ramp(input bit s);
    int n = s ? 100 : 16;
    for (int i = 0; i < 100; i++) img[i] = '0;
    for (int i = 0; i < n; i++) begin
      img[i][31:0] = 32'(i + 1);
      if (s) img[i][63:32] = 32'(-(i + 1));
    end
  endtask

  task automatic fill_rand(input bit s);
    for (int i = 0; i < 100; i++) begin
      img[i][31:0]  = $urandom;
      img[i][63:32] = s ? $urandom : 32'h0;
    end
  endtask

  // Reference: each output is the floor-mean or maximum of its 2x2 block.
  task automatic model(input bit s, input bit mx);
    int w = s ? 10 : 4;
    for (int orow = 0; orow < w / 2; orow++) begin
      for (int ocol = 0; ocol < w / 2; ocol++) begin
        logic [63:0] res = '0;
        for (int ln = 0; ln < 2; ln++) begin
          longint v [4];
          longint r, sum;
          logic [31:0] px;
          for (int k = 0; k < 4; k++) begin
            px   = img[(2 * orow + k / 2) * w + 2 * ocol + k % 2][ln*32 +: 32];
            v[k] = longint'($signed(px));
          end
          if (mx) begin
            r = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > r) r = v[k];
          end else begin
            sum = v[0] + v[1] + v[2] + v[3];
            r = sum / 4;
            if ((sum % 4) != 0 && sum < 0) r = r - 1;
          end
          res[ln*32 +: 32] = r[31:0];
        end
        exp_q.push_back(res);
      end
    end
  endtask

  // Runs one frame on the selected instance; abort_after > 0 stops driving
  // (at a falling edge) once that many beats were accepted.
  task automatic run_frame(input bit s, input bit mx, input bit stall, input int abort_after);
    int n_in = s ? 100 : 16;
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [63:0] expv;
    sel = s;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    mode = mx;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    mode    = ~mx;
    while (exp_q.size() > 0 && !(abort_after > 0 && idx >= abort_after)) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < n_in) begin
        in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        din      = img[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("busy_in_frame", bsy, 1);
      check("no_early_done", dn, 0);
      if (prev_stall) begin
        check("stall_valid_held", ov, 1);
        check("stall_data_held", od, prev_data);
      end
      if (ov && !out_ready) check("ready_low_when_stalled", ir, 0);
      if (ov && out_ready) begin
        expv = exp_q.pop_front();
        check("out_data", od, expv);
      end
      prev_stall = ov && !out_ready;
      prev_data  = od;
      if (in_valid && ir) idx++;
      cyc++;
      if (cyc > 5000) begin
        check("frame_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (abort_after == 0) begin
      out_ready = 1'b1;
      #1;
      check("all_beats_taken", idx, n_in);
      check("done_pulse", dn, 1);
      check("valid_clear_at_done", ov, 0);
      @(negedge clk);
      #1;
      check("done_one_cycle", dn, 0);
      check("idle_not_busy", bsy, 0);
      check("idle_not_ready", ir, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; din = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_in_ready", ir_a, 0);
    check("rst_a_out_valid", ov_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_out_data", od_a, 0);
    check("rst_b_in_ready", ir_b, 0);
    check("rst_b_out_valid", ov_b, 0);
    check("rst_b_out_data", od_b, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp 1..16, average then max.
    fill_ramp(0);
    exp_q = '{l0(3), l0(5), l0(11), l0(13)};
    run_frame(0, 0, 0, 0);
    fill_ramp(0);
    exp_q = '{l0(6), l0(8), l0(14), l0(16)};
    run_frame(0, 1, 0, 0);

    // Negative blocks: floor rounding and signed max.
    for (int i = 0; i < 100; i++) img[i] = '0;
    img[0] = l0(-1); img[1] = l0(-2); img[4] = l0(-3); img[5] = l0(-4);
    exp_q = '{l0(-3), l0(0), l0(0), l0(0)};
    run_frame(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) img[i] = l0(-9);
    img[0] = l0(-5); img[1] = l0(-1); img[4] = l0(-7); img[5] = l0(-3);
    exp_q = '{l0(-1), l0(-9), l0(-9), l0(-9)};
    run_frame(0, 1, 0, 0);

    // Random full-range data with gapped input and random backpressure.
    for (int k = 0; k < 6; k++) begin
      fill_rand(0);
      model(0, 1'(k));
      run_frame(0, 1'(k), 1, 0);
    end

    // Two lanes, 10x10: ramp and its negation, then random stalled frames.
    fill_ramp(1);
    model(1, 0);
    run_frame(1, 0, 0, 0);
    fill_rand(1);
    model(1, 1);
    run_frame(1, 1, 1, 0);
    fill_rand(1);
    model(1, 0);
    run_frame(1, 0, 1, 0);

    // Reset after 7 accepted beats, then a clean rerun of the first frame.
    fill_ramp(0);
    model(0, 0);
    run_frame(0, 0, 0, 7);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_not_busy", bsy, 0);
    check("abort_out_valid", ov, 0);
    check("abort_in_ready", ir, 0);
    check("abort_no_done", dn, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      #1;
      check("abort_no_done_later", dn, 0);
    end
    fill_ramp(0);
    exp_q = '{l0(3), l0(5), l0(11), l0(13)};
    run_frame(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
